// File: rtl/tdes_round_sequencer.sv
// Control FSM for an iterative Triple-DES datapath.
// Sequences one shared DES round engine through three 16-round passes
// (E-D-E for encrypt, D-E-D for decrypt) and presents per-cycle round,
// pass, key-select, direction and key-rotate controls to the datapath.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a block request, start_ready high
// LOAD     | datapath loads input block and applies IP
// ROUND    | one Feistel round per cycle, round_idx 0..NUM_ROUNDS-1
// PASS_END | datapath applies FP/swap for the finished pass
// DONE     | result valid, held until downstream accepts
module tdes_round_sequencer #(
    parameter int NUM_ROUNDS = 16,
    parameter int NUM_PASSES = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_valid,
    input  logic                          mode,
    output logic                          start_ready,
    input  logic                          abort,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic                          load_block,
    output logic                          round_en,
    output logic [$clog2(NUM_ROUNDS)-1:0] round_idx,
    output logic [1:0]                    pass_idx,
    output logic [1:0]                    key_sel,
    output logic                          decrypt,
    output logic [1:0]                    shift_amt,
    output logic                          pass_done,
    output logic                          busy
);

    localparam int RW = $clog2(NUM_ROUNDS);
    localparam logic [RW-1:0] R_LAST = RW'(NUM_ROUNDS - 1);
    localparam logic [1:0]    P_LAST = 2'(NUM_PASSES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        PASS_END,
        DONE
    } state_t;

    state_t        state, state_n;
    logic [RW-1:0] rnd_n;
    logic [1:0]    pas_n;
    logic          mode_q, mode_n;
    logic          pass_act_n;
    logic          dir_n;
    logic [1:0]    key_n;
    logic [1:0]    shift_n;

    // Next state, counters and latched mode; abort wins over normal flow
    // everywhere except IDLE so a coincident start is still accepted.
    always_comb begin
        state_n = state;
        rnd_n   = round_idx;
        pas_n   = pass_idx;
        mode_n  = mode_q;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    state_n = LOAD;
                    mode_n  = mode;
                    rnd_n   = '0;
                    pas_n   = '0;
                end
            end
            LOAD: begin
                state_n = ROUND;
            end
            ROUND: begin
                if (round_idx == R_LAST) begin
                    state_n = PASS_END;
                    rnd_n   = '0;
                end else begin
                    rnd_n = round_idx + 1'b1;
                end
            end
            PASS_END: begin
                if (pass_idx == P_LAST) begin
                    state_n = DONE;
                    pas_n   = '0;
                end else begin
                    state_n = ROUND;
                    pas_n   = pass_idx + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (abort && state != IDLE) begin
            state_n = IDLE;
            rnd_n   = '0;
            pas_n   = '0;
        end
    end

    // Key/direction/rotate decode of the next state so the outputs can be
    // registered alongside the state they describe.
    always_comb begin
        pass_act_n = (state_n == LOAD) || (state_n == ROUND) || (state_n == PASS_END);
        dir_n      = 1'b0;
        key_n      = 2'd0;
        shift_n    = 2'd0;
        if (pass_act_n) begin
            dir_n = mode_n ? ~pas_n[0] : pas_n[0];
            key_n = mode_n ? (P_LAST - pas_n) : pas_n;
        end
        if (state_n == ROUND) begin
            if (rnd_n == '0)
                shift_n = dir_n ? 2'd0 : 2'd1;
            else if (rnd_n == RW'(1) || rnd_n == RW'(8) || rnd_n == R_LAST)
                shift_n = 2'd1;
            else
                shift_n = 2'd2;
        end
    end

    // State, counters, latched mode and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            round_idx   <= '0;
            pass_idx    <= '0;
            mode_q      <= 1'b0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            load_block  <= 1'b0;
            round_en    <= 1'b0;
            pass_done   <= 1'b0;
            out_valid   <= 1'b0;
            key_sel     <= 2'd0;
            decrypt     <= 1'b0;
            shift_amt   <= 2'd0;
        end else begin
            state       <= state_n;
            round_idx   <= rnd_n;
            pass_idx    <= pas_n;
            mode_q      <= mode_n;
            start_ready <= (state_n == IDLE);
            busy        <= (state_n != IDLE);
            load_block  <= (state_n == LOAD);
            round_en    <= (state_n == ROUND);
            pass_done   <= (state_n == PASS_END);
            out_valid   <= (state_n == DONE);
            key_sel     <= key_n;
            decrypt     <= dir_n;
            shift_amt   <= shift_n;
        end
    end

endmodule

// File: tb/tb_tdes_round_sequencer.sv
// Self-checking bench for tdes_round_sequencer. Expected outputs come from a
// cycle-offset model: cycle k after acceptance maps to LOAD, a pass/round
// pair, a pass end, or the result phase by plain arithmetic.
module tb_tdes_round_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_valid;
    logic       mode;
    logic       start_ready;
    logic       abort;
    logic       out_ready;
    logic       out_valid;
    logic       load_block;
    logic       round_en;
    logic [3:0] round_idx;
    logic [1:0] pass_idx;
    logic [1:0] key_sel;
    logic       decrypt;
    logic [1:0] shift_amt;
    logic       pass_done;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    tdes_round_sequencer #(.NUM_ROUNDS(16), .NUM_PASSES(3)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .mode(mode),
        .start_ready(start_ready), .abort(abort), .out_ready(out_ready),
        .out_valid(out_valid), .load_block(load_block), .round_en(round_en),
        .round_idx(round_idx), .pass_idx(pass_idx), .key_sel(key_sel),
        .decrypt(decrypt), .shift_amt(shift_amt), .pass_done(pass_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] act_vec();
        return {start_ready, busy, load_block, round_en, round_idx, pass_idx,
                key_sel, decrypt, shift_amt, pass_done, out_valid};
    endfunction

    function automatic logic [16:0] mk(logic sr, logic bz, logic lb, logic re,
                                       logic [3:0] ri, logic [1:0] pi, logic [1:0] ks,
                                       logic dc, logic [1:0] sa, logic pd, logic ov);
        return {sr, bz, lb, re, ri, pi, ks, dc, sa, pd, ov};
    endfunction

    function automatic logic [16:0] idle_vec();
        return mk(1, 0, 0, 0, 4'd0, 2'd0, 2'd0, 0, 2'd0, 0, 0);
    endfunction

    function automatic logic [16:0] done_vec();
        return mk(0, 1, 0, 0, 4'd0, 2'd0, 2'd0, 0, 2'd0, 0, 1);
    endfunction

    // Expected outputs k cycles after acceptance (1 <= k <= 52).
    function automatic logic [16:0] model_vec(int k, logic m);
        int p, q, key;
        logic dec;
        logic [1:0] sa;
        if (k == 1) p = 0;
        else p = (k - 2) / 17;
        q = (k == 1) ? 0 : (k - 2) % 17;
        key = m ? (2 - p) : p;
        // encrypt passes are even in E-D-E; decrypt passes are even in D-E-D
        dec = m ? (p % 2 == 0) : (p % 2 == 1);
        if (k == 1)
            return mk(0, 1, 1, 0, 4'd0, 2'd0, 2'(key), dec, 2'd0, 0, 0);
        if (q == 16)
            return mk(0, 1, 0, 0, 4'd0, 2'(p), 2'(key), dec, 2'd0, 1, 0);
        if (q == 0)                          sa = dec ? 2'd0 : 2'd1;
        else if (q == 1 || q == 8 || q == 15) sa = 2'd1;
        else                                  sa = 2'd2;
        return mk(0, 1, 0, 1, 4'(q), 2'(p), 2'(key), dec, sa, 0, 0);
    endfunction

    // Run one request from an IDLE cycle. hold = extra cycles out_ready stays
    // low in DONE; noise toggles mode/start_valid/out_ready while busy;
    // abort_idle asserts abort in the acceptance cycle; abort_k (>0) asserts
    // abort in cycle k after acceptance.
    task automatic run_op(input string name, input logic m, input int hold,
                          input bit noise, input bit abort_idle, input int abort_k);
        int done_k, last_k;
        int n_round, n_pd, n_load, n_ov;
        logic [16:0] exp_v;
        n_round = 0; n_pd = 0; n_load = 0; n_ov = 0;
        done_k = 53 + hold;
        last_k = (abort_k != 0) ? abort_k + 3 : done_k + 2;
        vectors++;
        if (act_vec() !== idle_vec()) begin
            miscompares++;
            $display("FAIL %s pre_idle: got %h want %h", name, act_vec(), idle_vec());
        end
        start_valid = 1'b1;
        mode        = m;
        abort       = abort_idle;
        out_ready   = 1'b0;
        for (int k = 1; k <= last_k; k++) begin
            tick();
            if (abort_k != 0 && k > abort_k) exp_v = idle_vec();
            else if (k <= 52)                exp_v = model_vec(k, m);
            else if (k <= done_k)            exp_v = done_vec();
            else                             exp_v = idle_vec();
            vectors++;
            if (act_vec() !== exp_v) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %h want %h", name, k, act_vec(), exp_v);
            end
            n_round += int'(round_en);
            n_pd    += int'(pass_done);
            n_load  += int'(load_block);
            n_ov    += int'(out_valid);
            abort = (k == abort_k);
            if (k >= done_k || (abort_k != 0 && k >= abort_k)) begin
                start_valid = 1'b0;
                mode        = 1'b0;
            end else begin
                start_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                mode        = noise ? 1'($urandom_range(0, 1)) : m;
            end
            if (k >= 53) out_ready = (k == done_k);
            else         out_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        abort = 1'b0; out_ready = 1'b0; start_valid = 1'b0;
        if (abort_k == 0) begin
            vectors++;
            if (n_round != 48 || n_pd != 3 || n_load != 1 || n_ov != hold + 1) begin
                miscompares++;
                $display("FAIL %s counts: got rounds=%0d pd=%0d load=%0d ov=%0d want 48/3/1/%0d",
                         name, n_round, n_pd, n_load, n_ov, hold + 1);
            end
        end else if (abort_k <= 52) begin
            vectors++;
            if (n_ov != 0) begin
                miscompares++;
                $display("FAIL %s abort_no_out_valid: got %0d want 0", name, n_ov);
            end
        end
    endtask

    task automatic test_reset;
        int n_pd;
        logic [16:0] exp_v;
        rst = 1'b1; start_valid = 1'b0; mode = 1'b0; abort = 1'b0; out_ready = 1'b0;
        tick(); tick();
        vectors++;
        if (act_vec() !== idle_vec()) begin
            miscompares++;
            $display("FAIL reset_state: got %h want %h", act_vec(), idle_vec());
        end
        rst = 1'b0;
        tick();
        // mid-operation reset at pass 1 round 7 (k = 26)
        start_valid = 1'b1; mode = 1'b0;
        n_pd = 0;
        for (int k = 1; k <= 90; k++) begin
            tick();
            exp_v = (k <= 26) ? model_vec(k, 1'b0) : idle_vec();
            vectors++;
            if (act_vec() !== exp_v) begin
                miscompares++;
                $display("FAIL reset_midop cycle %0d: got %h want %h", k, act_vec(), exp_v);
            end
            if (k > 26) n_pd += int'(pass_done);
            start_valid = 1'b0;
            rst = (k == 26 || k == 27);
        end
        vectors++;
        if (n_pd != 0) begin
            miscompares++;
            $display("FAIL reset_no_pass_done: got %0d want 0", n_pd);
        end
    endtask

    task automatic test_encrypt;        run_op("encrypt", 1'b0, 0, 0, 0, 0); endtask
    task automatic test_decrypt;        run_op("decrypt", 1'b1, 0, 0, 0, 0); endtask
    task automatic test_backpressure;   run_op("backpressure", 1'b0, 10, 1, 0, 0); endtask
    task automatic test_mode_stability;
        run_op("mode_stab_enc", 1'b0, 0, 1, 0, 0);
        run_op("mode_stab_dec", 1'b1, 2, 1, 0, 0);
    endtask
    task automatic test_abort;
        run_op("abort_p2r3", 1'b0, 0, 0, 0, 39);
        run_op("after_abort", 1'b1, 0, 0, 0, 0);
        run_op("abort_in_done", 1'b1, 5, 0, 0, 55);
        run_op("abort_in_idle", 1'b0, 0, 0, 1, 0);
    endtask
    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++)
            run_op("random", 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 1, 1'($urandom_range(0, 1)), 0);
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_mode_stability();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
